// File: rtl/cpu_ram.sv
// cpu_ram: single-port synchronous CPU data/instruction RAM.
// After reset a hardware sweep clears every word to zero. When CPU_RAM_BOOT_EN
// is defined, a BOOT state then seeds address 0 with BOOT_WORD.
// Requests are served over a valid/ready channel, and reads return a registered
// response one cycle after acceptance.
module cpu_ram #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 4
`ifdef CPU_RAM_BOOT_EN
  ,
  parameter logic [DATA_W-1:0] BOOT_WORD = DATA_W'(16'h13F7)
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy
);

  localparam int unsigned       DEPTH     = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
`ifdef CPU_RAM_BOOT_EN
    ST_BOOT  = 2'd1,
`endif
    ST_IDLE  = 2'd2
  } state_t;

  state_t              state;
  logic [ADDR_W-1:0]   clear_ptr;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic                mem_we_c;
  logic [ADDR_W-1:0]   mem_waddr_c;
  logic [DATA_W-1:0]   mem_wdata_c;

  // Sequencer: sweep, optional boot seed, then request service with registered status
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_CLEAR;
      clear_ptr <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      req_ready <= 1'b0;
      busy      <= 1'b1;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        ST_CLEAR: begin
          clear_ptr <= clear_ptr + ADDR_W'(1);
          if (clear_ptr == LAST_ADDR) begin
`ifdef CPU_RAM_BOOT_EN
            state     <= ST_BOOT;
`else
            state     <= ST_IDLE;
            req_ready <= 1'b1;
            busy      <= 1'b0;
`endif
          end
        end
`ifdef CPU_RAM_BOOT_EN
        ST_BOOT: begin
          state     <= ST_IDLE;
          req_ready <= 1'b1;
          busy      <= 1'b0;
        end
`endif
        ST_IDLE: begin
          if (req_valid && req_ready && !req_we) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= mem[req_addr];
          end
        end
        default: begin
          state     <= ST_CLEAR;
          clear_ptr <= '0;
          req_ready <= 1'b0;
          busy      <= 1'b1;
        end
      endcase
    end
  end

  // Single write port: the sweep, the boot seed and accepted writes share it by state
  always_comb begin
    mem_we_c    = 1'b0;
    mem_waddr_c = clear_ptr;
    mem_wdata_c = '0;
    case (state)
      ST_CLEAR: begin
        mem_we_c = 1'b1;
      end
`ifdef CPU_RAM_BOOT_EN
      ST_BOOT: begin
        mem_we_c    = 1'b1;
        mem_waddr_c = '0;
        mem_wdata_c = BOOT_WORD;
      end
`endif
      ST_IDLE: begin
        if (req_valid && req_ready && req_we) begin
          mem_we_c    = 1'b1;
          mem_waddr_c = req_addr;
          mem_wdata_c = req_wdata;
        end
      end
      default: ;
    endcase
  end

  // Storage array; it is never reset directly, and a reset edge suppresses writes
  always_ff @(posedge clk) begin
    if (mem_we_c && !reset) begin
      mem[mem_waddr_c] <= mem_wdata_c;
    end
  end

endmodule

// File: tb/tb_cpu_ram.sv
// tb_cpu_ram: directed and random checks of cpu_ram against an array model.
module tb_cpu_ram;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DEPTH  = 16;
`ifdef CPU_RAM_BOOT_EN
  localparam int unsigned SWEEP  = DEPTH + 1;
`else
  localparam int unsigned SWEEP  = DEPTH;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_we = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [DATA_W-1:0] req_wdata = '0;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              busy;

  int n_cmp = 0;
  int n_err = 0;

  logic [DATA_W-1:0] model [DEPTH];
  logic [DATA_W-1:0] last_rd;

  cpu_ram dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Model of memory contents right after the sweep (and boot seed)
  task automatic model_clear();
    for (int i = 0; i < int'(DEPTH); i++) model[i] = '0;
`ifdef CPU_RAM_BOOT_EN
    model[0] = 16'h13F7;
`endif
    last_rd = '0;
  endtask

  // Release reset, count busy cycles until ready, optionally holding a write of FFFF to addr 2
  task automatic run_sweep(input bit hold);
    int  busy_cycles = 0;
    bit  done = 1'b0;
    @(negedge clk);
    reset     = 1'b0;
    req_valid = hold;
    req_we    = 1'b1;
    req_addr  = 4'd2;
    req_wdata = 16'hFFFF;
    for (int i = 0; i < 100 && !done; i++) begin
      if (i > 0) @(negedge clk);
      check("busy_vs_ready", 32'(busy), 32'(!req_ready));
      if (req_ready) begin
        done      = 1'b1;
        req_valid = 1'b0;
      end else begin
        busy_cycles++;
      end
    end
    check("ready_timeout", 32'(done), 32'd1);
    check("sweep_len", 32'(busy_cycles), 32'(SWEEP));
    model_clear();
  endtask

  // Assert reset for one edge (optionally with a read presented) and check reset state
  task automatic pulse_reset(input bit with_read);
    @(negedge clk);
    reset     = 1'b1;
    req_valid = with_read;
    req_we    = 1'b0;
    req_addr  = 4'd7;
    @(posedge clk);
    #1;
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_rdata", 32'(rsp_rdata), 32'd0);
  endtask

  // One clock of traffic; v=0 is an idle cycle
  task automatic op(input bit v, input bit we, input logic [ADDR_W-1:0] addr,
                    input logic [DATA_W-1:0] data);
    bit exp_v;
    @(negedge clk);
    if (v) check("ready", 32'(req_ready), 32'd1);
    req_valid = v;
    req_we    = we;
    req_addr  = addr;
    req_wdata = data;
    @(posedge clk);
    #1;
    exp_v = v && !we;
    if (v && we) model[addr] = data;
    if (exp_v) last_rd = model[addr];
    check("rsp_valid", 32'(rsp_valid), 32'(exp_v));
    check("rsp_rdata", 32'(rsp_rdata), 32'(last_rd));
  endtask

  initial begin
    bit                v, we;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;

    // Power-up reset and clear duration, then every word holds its post-sweep value
    repeat (2) @(posedge clk);
    #1;
    check("init_busy", 32'(busy), 32'd1);
    check("init_rsp_valid", 32'(rsp_valid), 32'd0);
    run_sweep(1'b0);
    for (int i = 0; i < int'(DEPTH); i++) op(1'b1, 1'b0, ADDR_W'(i), '0);
    op(1'b0, 1'b0, '0, '0);

    // Write then read after two idle cycles
    op(1'b1, 1'b1, 4'd5, 16'hBEEF);
    op(1'b0, 1'b0, '0, '0);
    op(1'b0, 1'b0, '0, '0);
    op(1'b1, 1'b0, 4'd5, '0);
    op(1'b0, 1'b0, '0, '0);
    check("beef_direct", 32'(last_rd), 32'h0000BEEF);

    // Back-to-back write, read-after-write, read neighbour
    op(1'b1, 1'b1, 4'd3, 16'h1234);
    op(1'b1, 1'b0, 4'd3, '0);
    check("raw_direct", 32'(rsp_rdata), 32'h00001234);
    op(1'b1, 1'b0, 4'd4, '0);
    check("b2b_zero", 32'(rsp_rdata), 32'h00000000);
    op(1'b0, 1'b0, '0, '0);

    // Write held throughout the sweep must be ignored
    pulse_reset(1'b0);
    run_sweep(1'b1);
    op(1'b1, 1'b0, 4'd2, '0);
    check("clear_ignored", 32'(rsp_rdata), 32'h00000000);
    op(1'b1, 1'b0, 4'd0, '0);

    // Reset coinciding with an accepted read drops the response and restarts the sweep
    op(1'b1, 1'b1, 4'd7, 16'hAAAA);
    op(1'b1, 1'b0, 4'd7, '0);
    check("aaaa_direct", 32'(rsp_rdata), 32'h0000AAAA);
    pulse_reset(1'b1);
    run_sweep(1'b0);
    op(1'b1, 1'b0, 4'd7, '0);
    check("reset_cleared", 32'(rsp_rdata), 32'h00000000);

    // Random traffic against the array model
    for (int n = 0; n < 400; n++) begin
      v  = ($urandom_range(0, 3) != 0);
      we = 1'($urandom_range(0, 1));
      a  = ADDR_W'($urandom_range(0, DEPTH - 1));
      d  = DATA_W'($urandom);
      op(v, we, a, d);
    end

    // Final read-back of every word
    for (int i = 0; i < int'(DEPTH); i++) op(1'b1, 1'b0, ADDR_W'(i), '0);
    op(1'b0, 1'b0, '0, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
